alu_rs_scheduler: RTL and testbench
===================================

# alu_rs_scheduler

Reservation station and issue scheduler for the single integer ALU. It buffers dispatched ALU/branch micro-ops and captures operand values from two result broadcast buses. Each cycle it selects one entry whose operands are both ready and drives the ALU's `status`/`OpCode`/`rs1`/`rs2`/`ROB_Number` inputs from registers. It sits between the decoder/dispatch stage and the ALU, and is flushed by the ROB `clear` on mispredict.

## Interface
- `RS_SIZE`, 8: number of entries, power of two, 2..16.
- `OP_W`, 6: opcode width, same encoding as the ALU opcode.
- `DATA_W`, 32: operand/value width.
- `TAG_W`, 5: ROB tag width.
- `clk_in`  in  1  clock; all state updates on rising edge.
- `rst_in`  in  1  reset, synchronous, active-high.
- `rdy_in`  in  1  global ready; low = stall.
- `clear`  in  1  flush from ROB, synchronous.
- `disp_valid`  in  1  dispatch request.
- `disp_op`  in  OP_W  opcode.
- `disp_vj`, `disp_vk`  in  DATA_W  operand values, valid when the matching `q*_busy` = 0.
- `disp_qj_busy`, `disp_qk_busy`  in  1  operand still pending.
- `disp_qj`, `disp_qk`  in  TAG_W  producer ROB tags.
- `disp_rob`  in  TAG_W  destination ROB tag.
- `full`  out  1  combinational; 1 when all entries are busy.
- `cdb_a_valid`, `cdb_b_valid`  in  1  broadcast valid (A = ALU result, B = load/store result).
- `cdb_a_tag`, `cdb_b_tag`  in  TAG_W  broadcast tag.
- `cdb_a_val`, `cdb_b_val`  in  DATA_W  broadcast value.
- `alu_status`  out  1  registered; issue valid to the ALU `status`.
- `alu_op`  out  OP_W  registered.
- `alu_rs1`, `alu_rs2`  out  DATA_W  registered.
- `alu_rob`  out  TAG_W  registered.

## Operation
- **Entry state:** `busy`, `op`, `vj`, `vk`, `qj_busy`, `qk_busy`, `qj`, `qk`, `rob`.
- **Ready:** an entry is ready when `busy & !qj_busy & !qk_busy`.
- **Per-cycle priority:** `rst_in` > `clear` > `rdy_in`=0 > normal.
- **Reset or clear:**
  - All `busy` = 0.
  - `alu_status` = 0.
  - `alu_op`, `alu_rs1`, `alu_rs2`, `alu_rob` = 0 on reset; unchanged on clear.
  - A `disp_valid` asserted in the same cycle is dropped.
- **Stall (`rdy_in`=0):**
  - No entry, tag or value changes.
  - No dispatch is accepted.
  - `alu_status` is forced to 0; the other issue outputs hold.
- **Dispatch:**
  - Accepted when `disp_valid & !full`.
  - Written into the lowest-index free entry.
  - `disp_valid` while `full` is ignored. Upstream must hold it; this block never overwrites a busy entry.
- **Dispatch bypass:** if a dispatched operand is pending and its tag matches a valid CDB in the same cycle:
  - The entry stores the CDB value with the pending flag cleared.
  - CDB A has precedence if both CDBs carry the same tag (illegal; defined for determinism only).
- **Wakeup:** for each busy entry and each operand with `q*_busy`=1 and a tag equal to a valid CDB tag, store the value and clear `q*_busy`. The j and k operands wake independently and may wake from different CDBs in the same cycle.
- **Select:**
  - Picks the lowest-index ready entry, using state as registered at the start of the cycle.
  - An entry dispatched or woken in cycle c is first selectable in cycle c+1.
- **Issue:**
  - The selected entry's fields load into `alu_op`, `alu_rs1` (=`vj`), `alu_rs2` (=`vk`) and `alu_rob`.
  - `alu_status` = 1 and the entry's `busy` = 0 at the same edge.
  - With no ready entry, `alu_status` = 0 and the other issue outputs hold.
- **Issue rate:** at most one issue per cycle. Dispatch and issue of different entries in the same cycle are both performed.
- **Freed entry reuse:** the slot freed by an issue is not reusable by the dispatch of that same cycle. `full` is computed from registered `busy`.

## Timing
- **Minimum latency:** dispatch of a fully ready op in cycle c → `alu_status`=1 during cycle c+1. The ALU result is on the CDB in cycle c+1 (the ALU is combinational).
- **Back-to-back dependents:**
  - Producer issued in cycle c broadcasts on CDB A in c.
  - A dependent waiting in the station wakes at the end of c and issues in c+2, one bubble.
- **`full`:** combinational from registered `busy`; valid throughout the cycle.
- **Reset mid-operation:** takes effect at the next edge; in-flight `alu_status` drops the same edge.
- **Clear with a pending issue:** the issue is suppressed and no ready entry survives.

## Test plan
- Reset, then dispatch `add` with vj=5, vk=7, both ready, rob=3 → next cycle `alu_status`=1, `alu_rs1`=5, `alu_rs2`=7, `alu_rob`=3; following cycle `alu_status`=0.
- Dispatch `sub` with qj_busy on tag 4; one cycle later CDB B tag=4, val=0x10 → issue two cycles after the broadcast with `alu_rs1`=0x10.
- Dispatch with qk tag 6 while CDB A tag=6, val=9 in the same cycle → issue next cycle with `alu_rs2`=9, no lost wakeup.
- Fill all 8 entries with pending ops → `full`=1 and a 9th `disp_valid` is ignored. Wake entries 5 and 2 together → entry 2 issues first, entry 5 the next cycle.
- Hold `rdy_in`=0 for 3 cycles with ready entries and a CDB pulse → `alu_status`=0, entries unchanged. After release, issue resumes from the lowest-index ready entry.
- Assert `clear` while 4 entries are busy and one is issuing → next cycle `alu_status`=0 and `full`=0; a fresh dispatch lands in entry 0.

Source files
------------

// File: rtl/alu_rs_scheduler.sv
// Reservation station and issue scheduler for the integer ALU.
// Buffers micro-ops, captures CDB results, issues one ready op per cycle.
module alu_rs_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int OP_W    = 6,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clear,
    input  logic              disp_valid,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [DATA_W-1:0] disp_vj,
    input  logic [DATA_W-1:0] disp_vk,
    input  logic              disp_qj_busy,
    input  logic              disp_qk_busy,
    input  logic [TAG_W-1:0]  disp_qj,
    input  logic [TAG_W-1:0]  disp_qk,
    input  logic [TAG_W-1:0]  disp_rob,
    output logic              full,
    input  logic              cdb_a_valid,
    input  logic [TAG_W-1:0]  cdb_a_tag,
    input  logic [DATA_W-1:0] cdb_a_val,
    input  logic              cdb_b_valid,
    input  logic [TAG_W-1:0]  cdb_b_tag,
    input  logic [DATA_W-1:0] cdb_b_val,
    output logic              alu_status,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_rs1,
    output logic [DATA_W-1:0] alu_rs2,
    output logic [TAG_W-1:0]  alu_rob
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qj_busy;
    logic [RS_SIZE-1:0] qk_busy;
    logic [RS_SIZE-1:0] ready;
    logic [OP_W-1:0]    op  [RS_SIZE];
    logic [DATA_W-1:0]  vj  [RS_SIZE];
    logic [DATA_W-1:0]  vk  [RS_SIZE];
    logic [TAG_W-1:0]   qj  [RS_SIZE];
    logic [TAG_W-1:0]   qk  [RS_SIZE];
    logic [TAG_W-1:0]   rob [RS_SIZE];

    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  free_idx;
    logic [DATA_W-1:0] d_vj;
    logic [DATA_W-1:0] d_vk;
    logic              d_qj_busy;
    logic              d_qk_busy;

    assign ready = busy & ~qj_busy & ~qk_busy;
    assign full  = &busy;

    // Lowest-index ready entry and lowest-index free entry, from registered state.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // Same-cycle CDB bypass for the operands being dispatched; CDB A wins ties.
    always_comb begin
        d_vj      = disp_vj;
        d_qj_busy = disp_qj_busy;
        d_vk      = disp_vk;
        d_qk_busy = disp_qk_busy;
        if (disp_qj_busy) begin
            if (cdb_a_valid && cdb_a_tag == disp_qj) begin
                d_vj      = cdb_a_val;
                d_qj_busy = 1'b0;
            end else if (cdb_b_valid && cdb_b_tag == disp_qj) begin
                d_vj      = cdb_b_val;
                d_qj_busy = 1'b0;
            end
        end
        if (disp_qk_busy) begin
            if (cdb_a_valid && cdb_a_tag == disp_qk) begin
                d_vk      = cdb_a_val;
                d_qk_busy = 1'b0;
            end else if (cdb_b_valid && cdb_b_tag == disp_qk) begin
                d_vk      = cdb_b_val;
                d_qk_busy = 1'b0;
            end
        end
    end

    // Station state: wakeup, issue and dispatch; stall freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy       <= '0;
            alu_status <= 1'b0;
            alu_op     <= '0;
            alu_rs1    <= '0;
            alu_rs2    <= '0;
            alu_rob    <= '0;
        end else if (clear) begin
            busy       <= '0;
            alu_status <= 1'b0;
        end else if (!rdy_in) begin
            alu_status <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && qj_busy[i]) begin
                    if (cdb_a_valid && cdb_a_tag == qj[i]) begin
                        vj[i]      <= cdb_a_val;
                        qj_busy[i] <= 1'b0;
                    end else if (cdb_b_valid && cdb_b_tag == qj[i]) begin
                        vj[i]      <= cdb_b_val;
                        qj_busy[i] <= 1'b0;
                    end
                end
                if (busy[i] && qk_busy[i]) begin
                    if (cdb_a_valid && cdb_a_tag == qk[i]) begin
                        vk[i]      <= cdb_a_val;
                        qk_busy[i] <= 1'b0;
                    end else if (cdb_b_valid && cdb_b_tag == qk[i]) begin
                        vk[i]      <= cdb_b_val;
                        qk_busy[i] <= 1'b0;
                    end
                end
            end
            alu_status <= sel_found;
            if (sel_found) begin
                busy[sel_idx] <= 1'b0;
                alu_op        <= op[sel_idx];
                alu_rs1       <= vj[sel_idx];
                alu_rs2       <= vk[sel_idx];
                alu_rob       <= rob[sel_idx];
            end
            if (disp_valid && !full) begin
                busy[free_idx]    <= 1'b1;
                op[free_idx]      <= disp_op;
                vj[free_idx]      <= d_vj;
                vk[free_idx]      <= d_vk;
                qj_busy[free_idx] <= d_qj_busy;
                qk_busy[free_idx] <= d_qk_busy;
                qj[free_idx]      <= disp_qj;
                qk[free_idx]      <= disp_qk;
                rob[free_idx]     <= disp_rob;
            end
        end
    end

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Randomized and directed bench for alu_rs_scheduler.
// Every output is compared each cycle against a behavioural station model.
module tb_alu_rs_scheduler;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        disp_valid;
    logic [5:0]  disp_op;
    logic [31:0] disp_vj;
    logic [31:0] disp_vk;
    logic        disp_qj_busy;
    logic        disp_qk_busy;
    logic [4:0]  disp_qj;
    logic [4:0]  disp_qk;
    logic [4:0]  disp_rob;
    logic        full;
    logic        cdb_a_valid;
    logic [4:0]  cdb_a_tag;
    logic [31:0] cdb_a_val;
    logic        cdb_b_valid;
    logic [4:0]  cdb_b_tag;
    logic [31:0] cdb_b_val;
    logic        alu_status;
    logic [5:0]  alu_op;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [4:0]  alu_rob;

    alu_rs_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .disp_valid(disp_valid), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_rob(disp_rob),
        .full(full),
        .cdb_a_valid(cdb_a_valid), .cdb_a_tag(cdb_a_tag), .cdb_a_val(cdb_a_val),
        .cdb_b_valid(cdb_b_valid), .cdb_b_tag(cdb_b_tag), .cdb_b_val(cdb_b_val),
        .alu_status(alu_status), .alu_op(alu_op),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_rob(alu_rob)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        busy;
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic        pj;
        logic        pk;
        logic [4:0]  tj;
        logic [4:0]  tk;
        logic [4:0]  rob;
    } ent_t;

    ent_t        m [8];
    logic        m_st;
    logic [5:0]  m_op;
    logic [31:0] m_rs1;
    logic [31:0] m_rs2;
    logic [4:0]  m_rob;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_full();
        for (int i = 0; i < 8; i++)
            if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    // Resolve a pending operand against whatever is on the CDBs now.
    task automatic snoop(input logic pend, input logic [4:0] tg,
                         input logic [31:0] v,
                         output logic [31:0] ov, output logic op);
        ov = v;
        op = pend;
        if (pend && cdb_a_valid && cdb_a_tag == tg) begin
            ov = cdb_a_val;
            op = 1'b0;
        end else if (pend && cdb_b_valid && cdb_b_tag == tg) begin
            ov = cdb_b_val;
            op = 1'b0;
        end
    endtask

    task automatic model_step();
        ent_t n [8];
        int   s;
        int   f;
        if (rst_in) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_st = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_rob = 0;
            return;
        end
        if (clear) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_st = 0;
            return;
        end
        if (!rdy_in) begin
            m_st = 0;
            return;
        end
        n = m;
        s = -1;
        f = -1;
        for (int i = 7; i >= 0; i--) begin
            if (m[i].busy && !m[i].pj && !m[i].pk) s = i;
            if (!m[i].busy) f = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (m[i].busy) begin
                snoop(m[i].pj, m[i].tj, m[i].vj, n[i].vj, n[i].pj);
                snoop(m[i].pk, m[i].tk, m[i].vk, n[i].vk, n[i].pk);
            end
        end
        m_st = (s >= 0);
        if (s >= 0) begin
            n[s].busy = 1'b0;
            m_op  = m[s].op;
            m_rs1 = m[s].vj;
            m_rs2 = m[s].vk;
            m_rob = m[s].rob;
        end
        if (disp_valid && f >= 0) begin
            n[f].busy = 1'b1;
            n[f].op   = disp_op;
            n[f].tj   = disp_qj;
            n[f].tk   = disp_qk;
            n[f].rob  = disp_rob;
            snoop(disp_qj_busy, disp_qj, disp_vj, n[f].vj, n[f].pj);
            snoop(disp_qk_busy, disp_qk, disp_vk, n[f].vk, n[f].pk);
        end
        m = n;
    endtask

    task automatic idle();
        rst_in = 0; clear = 0; rdy_in = 1;
        disp_valid = 0; disp_op = 0; disp_vj = 0; disp_vk = 0;
        disp_qj_busy = 0; disp_qk_busy = 0;
        disp_qj = 0; disp_qk = 0; disp_rob = 0;
        cdb_a_valid = 0; cdb_a_tag = 0; cdb_a_val = 0;
        cdb_b_valid = 0; cdb_b_tag = 0; cdb_b_val = 0;
    endtask

    task automatic cyc();
        chk("full", full, m_full());
        model_step();
        @(posedge clk_in);
        #1;
        chk("status", alu_status, m_st);
        chk("op", alu_op, m_op);
        chk("rs1", alu_rs1, m_rs1);
        chk("rs2", alu_rs2, m_rs2);
        chk("rob", alu_rob, m_rob);
    endtask

    task automatic disp(input logic [5:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic pa, input logic [4:0] ta,
                        input logic pb, input logic [4:0] tb, input logic [4:0] r);
        disp_valid = 1; disp_op = o; disp_vj = a; disp_vk = b;
        disp_qj_busy = pa; disp_qj = ta;
        disp_qk_busy = pb; disp_qk = tb; disp_rob = r;
    endtask

    initial begin
        idle();
        rst_in = 1;
        model_step();
        @(posedge clk_in);
        #1;
        cyc();
        chk("rst_status", alu_status, 0);
        chk("rst_full", full, 0);
        idle();

        disp(6'h01, 5, 7, 0, 0, 0, 0, 3);
        cyc();
        idle();
        cyc();
        chk("add_st", alu_status, 1);
        chk("add_rs1", alu_rs1, 5);
        chk("add_rs2", alu_rs2, 7);
        chk("add_rob", alu_rob, 3);
        cyc();
        chk("add_idle", alu_status, 0);

        disp(6'h02, 0, 1, 1, 4, 0, 0, 8);
        cyc();
        idle();
        cyc();
        cdb_b_valid = 1; cdb_b_tag = 4; cdb_b_val = 32'h10;
        cyc();
        idle();
        cyc();
        chk("sub_st", alu_status, 1);
        chk("sub_rs1", alu_rs1, 32'h10);
        cyc();

        disp(6'h03, 2, 0, 0, 0, 1, 6, 9);
        cdb_a_valid = 1; cdb_a_tag = 6; cdb_a_val = 9;
        cyc();
        idle();
        cyc();
        chk("byp_st", alu_status, 1);
        chk("byp_rs2", alu_rs2, 9);
        cyc();

        for (int i = 0; i < 8; i++) begin
            disp(6'(i + 4), 32'(i), 32'(i), 1, 5'(10 + i), 0, 0, 5'(i));
            cyc();
        end
        chk("fill_full", full, 1);
        disp(6'h3f, 1, 1, 0, 0, 0, 0, 31);
        cyc();
        idle();
        cdb_a_valid = 1; cdb_a_tag = 15; cdb_a_val = 55;
        cdb_b_valid = 1; cdb_b_tag = 12; cdb_b_val = 22;
        cyc();
        idle();
        cyc();
        chk("e2_rob", alu_rob, 2);
        cyc();
        chk("e5_rob", alu_rob, 5);

        cdb_a_valid = 1; cdb_a_tag = 10; cdb_a_val = 100;
        cdb_b_valid = 1; cdb_b_tag = 11; cdb_b_val = 111;
        rdy_in = 0;
        cyc();
        idle();
        rdy_in = 0;
        cdb_a_valid = 1; cdb_a_tag = 13; cdb_a_val = 13;
        cyc();
        idle();
        rdy_in = 0;
        cyc();
        chk("stall_st", alu_status, 0);
        idle();
        cdb_a_valid = 1; cdb_a_tag = 10; cdb_a_val = 100;
        cdb_b_valid = 1; cdb_b_tag = 11; cdb_b_val = 111;
        cyc();
        idle();
        cyc();
        chk("resume_rob", alu_rob, 0);
        cyc();

        clear = 1;
        cyc();
        chk("clr_st", alu_status, 0);
        chk("clr_full", full, 0);
        idle();
        disp(6'h07, 77, 88, 0, 0, 0, 0, 20);
        cyc();
        idle();
        cyc();
        chk("post_clr", alu_rs1, 77);

        for (int c = 0; c < 4000; c++) begin
            idle();
            rst_in = ($urandom_range(0, 199) == 0);
            clear  = ($urandom_range(0, 39) == 0);
            rdy_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 2) != 0)
                disp(6'($urandom), $urandom, $urandom,
                     1'($urandom), 5'($urandom_range(0, 7)),
                     1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom));
            cdb_a_valid = 1'($urandom);
            cdb_a_tag   = 5'($urandom_range(0, 7));
            cdb_a_val   = $urandom;
            cdb_b_valid = 1'($urandom);
            cdb_b_tag   = 5'($urandom_range(0, 7));
            cdb_b_val   = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
